vga_plot_sink: RTL and testbench
================================

# vga_plot_sink

Receiving end of the CPU's VGA plot interface. It accepts pixel plot requests (colour, x, y, plot strobe) from the flow core and buffers them in a 4-entry FIFO. It converts each request to a linear framebuffer address and writes it through a stallable single-port write interface. It also performs full-screen clear sweeps. It sits between the CPU top and the 160x120 15-bit framebuffer RAM that feeds the VGA scan-out.

## Interface
Parameters:
- WIDTH, 160, visible columns
- HEIGHT, 120, visible rows
- DEPTH, 4, plot FIFO entries (power of two)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- plot  in  1  plot request strobe
- plot_color  in  15  pixel colour
- plot_x  in  8  column
- plot_y  in  7  row
- plot_ready  out  1  request accepted when plot && plot_ready
- clear_req  in  1  single-cycle clear request
- clear_color  in  15  fill colour, sampled with clear_req
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  15  linear address y*WIDTH + x
- fb_data  out  15  write data
- fb_wait  in  1  RAM stall; holds the current write
- busy  out  1  CLEAR state, or FIFO non-empty, or fb_we
- clear_done  out  1  one-cycle pulse at end of sweep
- oob_flag  out  1  sticky flag: an out-of-range request was seen

## Operation
- States: RUN and CLEAR. Reset state is RUN.
- Request intake, in either state: on plot && plot_ready:
  - If x >= WIDTH or y >= HEIGHT, the request is consumed, not enqueued, and oob_flag is set.
  - Otherwise {color, addr} is pushed. addr = (y<<7) + (y<<5) + x, computed at 15 bits with no overflow (max 19199).
- plot_ready = FIFO count < DEPTH. It is combinational from registered count only, not from plot.
- RUN:
  - When the output is free, the FIFO is non-empty, and clear_req is low, pop the head into fb_addr/fb_data and assert fb_we.
  - The output is free when fb_we is low, or when fb_we is high and fb_wait is low.
- clear_req in RUN:
  - Flushes the FIFO, including any request accepted in the same cycle.
  - Latches clear_color.
  - Clears oob_flag.
  - Enters CLEAR. A write in flight completes normally first.
- CLEAR:
  - Writes addresses 0..WIDTH*HEIGHT-1 in order, one per free output cycle, with the latched colour.
  - New plot requests are enqueued normally and drained only after returning to RUN.
  - clear_req in CLEAR is ignored.
  - After the final address is accepted (fb_we && !fb_wait), pulse clear_done for one cycle and return to RUN.
- fb_wait semantics: while fb_we && fb_wait, fb_we, fb_addr and fb_data hold unchanged.
- Push and pop in the same cycle: count is unchanged.
- Empty FIFO: no pop.
- Full FIFO: plot_ready is low.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - state RUN
  - FIFO empty, so plot_ready = 1
  - fb_we = 0, fb_addr = 0, fb_data = 0
  - busy = 0, clear_done = 0, oob_flag = 0
  - latched clear colour = 0
- Reset asserted mid-sweep or mid-write aborts immediately. There is no clear_done and the FIFO contents are lost.
- Plot latency: request accepted at edge N, into an empty FIFO with an idle output, gives fb_we high in the cycle following edge N+1. That is 2 cycles from request to write.
- Sustained throughput: 1 write per cycle with fb_wait low.
- Clear: clear_req at edge N gives the first sweep write (addr 0) visible after edge N+1.
  - A full sweep with no stalls takes 19200 consecutive fb_we cycles.
  - clear_done is high for the cycle after the last write is accepted.
- All outputs are registered except plot_ready and busy, which are derived from registers only.

## Test plan
- Basic plot: after reset, plot x=3, y=2, color=0x7FFF. Expect exactly one fb_we cycle, 2 cycles later, with fb_addr=323 and fb_data=0x7FFF; then busy=0.
- Corners: plot (0,0) then (159,119). Expect addresses 0 then 19199 in order, on back-to-back cycles.
- Out of range: plot x=160, y=5. Expect it accepted, no fb_we, oob_flag=1. A following clear_req returns oob_flag to 0.
- Backpressure:
  - Hold fb_wait=1 and issue 6 plots. Expect the first popped write held stable, 4 further requests enqueued, and plot_ready=0.
  - Release fb_wait. Expect all 5 writes in order with no loss or duplication.
- Clear with concurrent plots: clear_req with clear_color=0x001F while plotting (10,10).
  - Expect the request flushed.
  - Expect 19200 writes of 0x001F at addresses 0..19199.
  - Expect clear_done for one cycle.
  - Expect plots issued during the sweep written afterwards.
- Reset mid-sweep: assert reset at sweep address 5000. Expect fb_we=0 immediately, no clear_done, plot_ready=1, and normal plots working after release.

Source files
------------

// File: rtl/vga_plot_sink.sv
// Receiving end of the CPU VGA plot interface: buffers plot requests in a small FIFO,
// turns them into linear framebuffer writes, and runs full-screen clear sweeps.
module vga_plot_sink #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        plot,
  input  logic [14:0] plot_color,
  input  logic [7:0]  plot_x,
  input  logic [6:0]  plot_y,
  output logic        plot_ready,
  input  logic        clear_req,
  input  logic [14:0] clear_color,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [14:0] fb_data,
  input  logic        fb_wait,
  output logic        busy,
  output logic        clear_done,
  output logic        oob_flag
);

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 15;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = PW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);

  typedef enum logic [0:0] {RUN, CLEAR} state_t;

  typedef struct packed {
    logic [DW-1:0] color;
    logic [AW-1:0] addr;
  } entry_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [NW-1:0] count, count_nxt;
  logic          fb_we_nxt, clear_done_nxt, oob_flag_nxt;
  logic [AW-1:0] fb_addr_nxt, sweep_addr, sweep_addr_nxt;
  logic [DW-1:0] fb_data_nxt, clr_color, clr_color_nxt;
  logic          last_issued, last_issued_nxt;

  logic          in_range_c, accept_c, flush_c, push_c, pop_c, out_free_c;
  logic [AW-1:0] plot_addr_c;
  entry_t        head_c;

  assign plot_ready = (count < NW'(DEPTH));
  assign busy       = (state == CLEAR) || (count != '0) || fb_we;

  // y*160 + x as shift-and-add; bounded by the range check so it never overflows
  assign plot_addr_c = (AW'(plot_y) << 7) + (AW'(plot_y) << 5) + AW'(plot_x);
  assign in_range_c  = (32'(plot_x) < WIDTH) && (32'(plot_y) < HEIGHT);
  assign accept_c    = plot && plot_ready;
  assign out_free_c  = !fb_we || !fb_wait;
  assign flush_c     = (state == RUN) && clear_req;
  assign push_c      = accept_c && in_range_c && !flush_c;
  assign pop_c       = (state == RUN) && !clear_req && out_free_c && (count != '0);
  assign head_c      = mem[rd_ptr];

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (push_c) mem[wr_ptr] <= '{color: plot_color, addr: plot_addr_c};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt       = state;
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;
    count_nxt       = count;
    fb_we_nxt       = fb_we;
    fb_addr_nxt     = fb_addr;
    fb_data_nxt     = fb_data;
    clear_done_nxt  = 1'b0;
    oob_flag_nxt    = oob_flag;
    clr_color_nxt   = clr_color;
    sweep_addr_nxt  = sweep_addr;
    last_issued_nxt = last_issued;

    if (out_free_c) fb_we_nxt = 1'b0;
    if (accept_c && !in_range_c) oob_flag_nxt = 1'b1;
    if (push_c) wr_ptr_nxt = wr_ptr + PW'(1);
    if (pop_c)  rd_ptr_nxt = rd_ptr + PW'(1);
    count_nxt = count + NW'(push_c) - NW'(pop_c);

    unique case (state)
      RUN: begin
        if (clear_req) begin
          state_nxt       = CLEAR;
          wr_ptr_nxt      = '0;
          rd_ptr_nxt      = '0;
          count_nxt       = '0;
          oob_flag_nxt    = 1'b0;
          clr_color_nxt   = clear_color;
          sweep_addr_nxt  = '0;
          last_issued_nxt = 1'b0;
        end else if (pop_c) begin
          fb_we_nxt   = 1'b1;
          fb_addr_nxt = head_c.addr;
          fb_data_nxt = head_c.color;
        end
      end
      CLEAR: begin
        if (out_free_c) begin
          if (last_issued) begin
            // final sweep write is being accepted this cycle
            state_nxt      = RUN;
            clear_done_nxt = 1'b1;
          end else begin
            fb_we_nxt       = 1'b1;
            fb_addr_nxt     = sweep_addr;
            fb_data_nxt     = clr_color;
            sweep_addr_nxt  = sweep_addr + AW'(1);
            last_issued_nxt = (sweep_addr == LAST_ADDR);
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      clear_done  <= 1'b0;
      oob_flag    <= 1'b0;
      clr_color   <= '0;
      sweep_addr  <= '0;
      last_issued <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      fb_we       <= fb_we_nxt;
      fb_addr     <= fb_addr_nxt;
      fb_data     <= fb_data_nxt;
      clear_done  <= clear_done_nxt;
      oob_flag    <= oob_flag_nxt;
      clr_color   <= clr_color_nxt;
      sweep_addr  <= sweep_addr_nxt;
      last_issued <= last_issued_nxt;
    end
  end

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink: plots, corners, out-of-range, backpressure,
// clear sweep with concurrent plots and reset mid-sweep.
module tb_vga_plot_sink;

  logic        clock = 1'b0;
  logic        reset;
  logic        plot;
  logic [14:0] plot_color;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic        plot_ready;
  logic        clear_req;
  logic [14:0] clear_color;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [14:0] fb_data;
  logic        fb_wait;
  logic        busy;
  logic        clear_done;
  logic        oob_flag;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int done_cnt = 0;

  logic [14:0] log_addr[$];
  logic [14:0] log_data[$];
  int          log_cyc[$];

  vga_plot_sink dut (
    .clock(clock), .reset(reset), .plot(plot), .plot_color(plot_color),
    .plot_x(plot_x), .plot_y(plot_y), .plot_ready(plot_ready),
    .clear_req(clear_req), .clear_color(clear_color), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wait(fb_wait), .busy(busy),
    .clear_done(clear_done), .oob_flag(oob_flag)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Accepted writes and clear_done pulses, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset && fb_we && !fb_wait) begin
      log_addr.push_back(fb_addr);
      log_data.push_back(fb_data);
      log_cyc.push_back(cyc);
    end
    if (clear_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic drive_plot(input logic [7:0] x, input logic [6:0] y, input logic [14:0] c);
    plot = 1'b1; plot_x = x; plot_y = y; plot_color = c;
  endtask

  initial begin
    int errs;
    int start;
    int k;
    reset = 1'b1; plot = 1'b0; plot_color = '0; plot_x = '0; plot_y = '0;
    clear_req = 1'b0; clear_color = '0; fb_wait = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);

    // reset state
    check("rst_ready", 32'(plot_ready), 1);
    check("rst_we", 32'(fb_we), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_data", 32'(fb_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(clear_done), 0);
    check("rst_oob", 32'(oob_flag), 0);

    // basic plot: 3 + 2*160 = 323, write visible after the second edge
    clear_log();
    drive_plot(8'd3, 7'd2, 15'h7FFF);
    step(1);
    plot = 1'b0;
    check("basic_we_n", 32'(fb_we), 0);
    step(1);
    check("basic_we", 32'(fb_we), 1);
    check("basic_addr", 32'(fb_addr), 323);
    check("basic_data", 32'(fb_data), 32'h7FFF);
    step(1);
    check("basic_we_off", 32'(fb_we), 0);
    check("basic_busy", 32'(busy), 0);
    check("basic_count", 32'(log_addr.size()), 1);

    // corners back to back
    clear_log();
    drive_plot(8'd0, 7'd0, 15'h0011);
    step(1);
    drive_plot(8'd159, 7'd119, 15'h0022);
    step(1);
    plot = 1'b0;
    step(4);
    check("corner_count", 32'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      check("corner_a0", 32'(log_addr[0]), 0);
      check("corner_a1", 32'(log_addr[1]), 19199);
      check("corner_d1", 32'(log_data[1]), 32'h0022);
      check("corner_b2b", 32'(log_cyc[1] - log_cyc[0]), 1);
    end

    // out of range: consumed, not written, sticky flag
    clear_log();
    drive_plot(8'd160, 7'd5, 15'h0033);
    check("oob_ready", 32'(plot_ready), 1);
    step(1);
    plot = 1'b0;
    step(4);
    check("oob_writes", 32'(log_addr.size()), 0);
    check("oob_flag", 32'(oob_flag), 1);

    // clear sweep with a concurrent (flushed) plot and plots during the sweep
    clear_log();
    start = done_cnt;
    clear_req = 1'b1; clear_color = 15'h001F;
    drive_plot(8'd10, 7'd10, 15'h0444);
    step(1);
    clear_req = 1'b0; plot = 1'b0; clear_color = '0;
    check("clr_oob_cleared", 32'(oob_flag), 0);
    check("clr_busy", 32'(busy), 1);
    step(1);
    check("clr_first_we", 32'(fb_we), 1);
    check("clr_first_addr", 32'(fb_addr), 0);
    step(100);
    drive_plot(8'd1, 7'd1, 15'h1234);
    step(1);
    drive_plot(8'd2, 7'd0, 15'h0ABC);
    step(1);
    plot = 1'b0;
    k = 0;
    while (done_cnt == start && k < 25000) begin
      step(1);
      k++;
    end
    check("clr_done_seen", 32'(done_cnt != start), 1);
    step(6);
    check("clr_done_pulses", 32'(done_cnt - start), 1);
    check("clr_total", 32'(log_addr.size()), 19202);
    if (log_addr.size() == 19202) begin
      errs = 0;
      for (int i = 0; i < 19200; i++)
        if (log_addr[i] !== 15'(i) || log_data[i] !== 15'h001F) errs++;
      check("clr_sweep_errs", 32'(errs), 0);
      check("clr_consecutive", 32'(log_cyc[19199] - log_cyc[0]), 19199);
      check("clr_post_a0", 32'(log_addr[19200]), 161);
      check("clr_post_d0", 32'(log_data[19200]), 32'h1234);
      check("clr_post_a1", 32'(log_addr[19201]), 2);
      check("clr_post_d1", 32'(log_data[19201]), 32'h0ABC);
    end
    check("clr_idle", 32'(busy), 0);

    // backpressure: first write held, four queued, sixth refused
    clear_log();
    fb_wait = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_plot(8'(20 + i), 7'd1, 15'(16'h0100 + i));
      step(1);
    end
    plot = 1'b0;
    check("bp_ready", 32'(plot_ready), 0);
    check("bp_we", 32'(fb_we), 1);
    check("bp_addr", 32'(fb_addr), 180);
    check("bp_data", 32'(fb_data), 32'h0100);
    step(3);
    check("bp_hold_addr", 32'(fb_addr), 180);
    check("bp_hold_we", 32'(fb_we), 1);
    fb_wait = 1'b0;
    step(8);
    check("bp_count", 32'(log_addr.size()), 5);
    if (log_addr.size() == 5) begin
      errs = 0;
      for (int i = 0; i < 5; i++)
        if (log_addr[i] !== 15'(180 + i) || log_data[i] !== 15'(16'h0100 + i)) errs++;
      check("bp_order_errs", 32'(errs), 0);
    end

    // reset mid-sweep at address 5000
    start = done_cnt;
    clear_req = 1'b1; clear_color = 15'h7C00;
    step(1);
    clear_req = 1'b0;
    k = 0;
    while (!(fb_we && fb_addr == 15'd5000) && k < 6000) begin
      step(1);
      k++;
    end
    check("mid_reached", 32'(fb_we && fb_addr == 15'd5000), 1);
    reset = 1'b1;
    #1;
    check("mid_we", 32'(fb_we), 0);
    check("mid_ready", 32'(plot_ready), 1);
    check("mid_busy", 32'(busy), 0);
    step(2);
    reset = 1'b0;
    step(3);
    check("mid_no_done", 32'(done_cnt - start), 0);
    clear_log();
    drive_plot(8'd7, 7'd3, 15'h2222);
    step(1);
    plot = 1'b0;
    step(4);
    check("mid_plot_count", 32'(log_addr.size()), 1);
    if (log_addr.size() == 1) begin
      check("mid_plot_addr", 32'(log_addr[0]), 487);
      check("mid_plot_data", 32'(log_data[0]), 32'h2222);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
